// File: rtl/mem_wb_multi.sv
// MEM/WB pipeline register for a multi-lane issue group with configurable depth.
// Every stage carries one whole issue group. Same-address register writes within a
// group are resolved in favour of the youngest lane. Lanes that reach WB are counted.
module mem_wb_multi #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [5:0]                stall,
    input  logic                      flush,
    input  logic [LANES-1:0]          mem_valid,
    input  logic [LANES*ADDR_W-1:0]   mem_wd,
    input  logic [LANES-1:0]          mem_wreg,
    input  logic [LANES*DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]         mem_hi,
    input  logic [DATA_W-1:0]         mem_lo,
    input  logic                      mem_whilo,
    input  logic                      mem_llbit_we,
    input  logic                      mem_llbit_value,
    output logic [LANES-1:0]          wb_valid,
    output logic [LANES*ADDR_W-1:0]   wb_wd,
    output logic [LANES-1:0]          wb_wreg,
    output logic [LANES*DATA_W-1:0]   wb_wdata,
    output logic [DATA_W-1:0]         wb_hi,
    output logic [DATA_W-1:0]         wb_lo,
    output logic                      wb_whilo,
    output logic                      wb_llbit_we,
    output logic                      wb_llbit_value,
    output logic [31:0]               retire_cnt
);

    typedef struct packed {
        logic [LANES-1:0]        valid;
        logic [LANES*ADDR_W-1:0] wd;
        logic [LANES-1:0]        wreg;
        logic [LANES*DATA_W-1:0] wdata;
        logic [DATA_W-1:0]       hi;
        logic [DATA_W-1:0]       lo;
        logic                    whilo;
        logic                    llbit_we;
        logic                    llbit_value;
    } stage_t;

    stage_t           stage_q [DEPTH];
    stage_t           stage_d [DEPTH];
    stage_t           load_s;
    logic [LANES-1:0] qual;
    logic [LANES-1:0] keep;
    logic             final_load;
    logic [31:0]      retire_cnt_q;
    logic [31:0]      retire_cnt_d;

    // Stall bits for other pipeline stages are not used here.
    logic unused_stall;
    assign unused_stall = ^stall[3:0];

    // Qualify lane writes (no r0, valid only); a younger lane to the same address wins.
    always_comb begin
        qual = '0;
        keep = '0;
        for (int i = 0; i < LANES; i++) begin
            qual[i] = mem_valid[i] & mem_wreg[i] & (mem_wd[i*ADDR_W +: ADDR_W] != '0);
        end
        for (int i = 0; i < LANES; i++) begin
            keep[i] = qual[i];
            for (int j = i + 1; j < LANES; j++) begin
                if (qual[j] && (mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[i*ADDR_W +: ADDR_W])) begin
                    keep[i] = 1'b0;
                end
            end
        end
    end

    // Form the group that stage 1 captures; group-wide side effects need a live lane.
    always_comb begin
        load_s             = '0;
        load_s.valid       = mem_valid;
        load_s.wd          = mem_wd;
        load_s.wreg        = keep;
        load_s.wdata       = mem_wdata;
        load_s.hi          = mem_hi;
        load_s.lo          = mem_lo;
        load_s.whilo       = mem_whilo & (|mem_valid);
        load_s.llbit_we    = mem_llbit_we & (|mem_valid);
        load_s.llbit_value = mem_llbit_value;
    end

    // Next state for every stage: reset/flush clear all, MEM stall feeds a bubble,
    // WB stall freezes the downstream stages.
    always_comb begin
        stage_d = stage_q;
        if (rst || flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_d[k] = '0;
            end
        end else begin
            if (stall[4] && !stall[5]) begin
                stage_d[0] = '0;
            end else if (!stall[4]) begin
                stage_d[0] = load_s;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (!stall[5]) begin
                    stage_d[k] = stage_q[k-1];
                end
            end
        end
    end

    // Count lanes retiring into the final stage; only genuine loads count.
    always_comb begin
        if (DEPTH == 1) begin
            final_load = !rst && !flush && !stall[4];
        end else begin
            final_load = !rst && !flush && !stall[5];
        end
        retire_cnt_d = retire_cnt_q;
        if (rst) begin
            retire_cnt_d = '0;
        end else if (final_load) begin
            retire_cnt_d = retire_cnt_q + 32'($countones(stage_d[DEPTH-1].valid));
        end
    end

    // State registers; reset is folded into the next-state logic.
    always_ff @(posedge clk) begin
        stage_q      <= stage_d;
        retire_cnt_q <= retire_cnt_d;
    end

    assign wb_valid       = stage_q[DEPTH-1].valid;
    assign wb_wd          = stage_q[DEPTH-1].wd;
    assign wb_wreg        = stage_q[DEPTH-1].wreg;
    assign wb_wdata       = stage_q[DEPTH-1].wdata;
    assign wb_hi          = stage_q[DEPTH-1].hi;
    assign wb_lo          = stage_q[DEPTH-1].lo;
    assign wb_whilo       = stage_q[DEPTH-1].whilo;
    assign wb_llbit_we    = stage_q[DEPTH-1].llbit_we;
    assign wb_llbit_value = stage_q[DEPTH-1].llbit_value;
    assign retire_cnt     = retire_cnt_q;

endmodule

// File: doc/mem_wb_multi.md
MEM_WB_MULTI -- requirements
Module: mem_wb_multi

Interface
REQ-001 SHALL provide parameter LANES, default 2: number of issue lanes carried per pipeline group (legal 1..4).
REQ-002 SHALL provide parameter DATA_W, default 32: width of register-file data, HI and LO.
REQ-003 SHALL provide parameter ADDR_W, default 5: width of register-file write address.
REQ-004 SHALL provide parameter DEPTH, default 1: number of register stages between the MEM and WB sides (legal 1..3).
REQ-005 SHALL provide the following ports, in this order:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- stall  in  6  pipeline stall vector; bit4 = MEM stalled, bit5 = WB stalled.
- flush  in  1  exception flush; discards all in-flight groups.
- mem_valid  in  LANES  lane holds a real instruction.
- mem_wd  in  LANES*ADDR_W  per-lane destination address; lane i at bits [i*ADDR_W +: ADDR_W].
- mem_wreg  in  LANES  per-lane register write enable.
- mem_wdata  in  LANES*DATA_W  per-lane write data.
- mem_hi, mem_lo  in  DATA_W each  HI/LO values for the group.
- mem_whilo  in  1  HI/LO write enable for the group.
- mem_llbit_we, mem_llbit_value  in  1 each  LL-bit update for the group.
- wb_valid, wb_wd, wb_wreg, wb_wdata  out  same widths as the mem_ counterparts  registered WB-side copies.
- wb_hi, wb_lo, wb_whilo, wb_llbit_we, wb_llbit_value  out  registered WB-side copies.
- retire_cnt  out  32  running count of retired lanes.

Function
REQ-006 SHALL hold a pipeline of DEPTH stages; stage 1 loads from the mem_ inputs, and stage k loads from stage k-1.
REQ-007 SHALL drive all wb_ outputs directly from the final stage's registers; no combinational path SHALL exist from inputs to outputs.
REQ-008 Stage 1 update, in priority order:
- rst, then flush: load bubble.
- stall[4]=1 and stall[5]=0: load bubble.
- stall[4]=1 and stall[5]=1: hold.
- stall[4]=0: load inputs.
REQ-009 Stages 2..DEPTH update, in priority order:
- rst or flush: load bubble.
- stall[5]=1: hold.
- otherwise: load from the previous stage.
REQ-010 A bubble SHALL set the following fields to 0: valid, wd, wreg, wdata, hi, lo, whilo, llbit_we and llbit_value.
REQ-011 On load into stage 1, each lane's stored wreg SHALL be mem_valid[i] & mem_wreg[i] & (mem_wd[i] != 0); writes to register 0 are suppressed.
REQ-012 On load into stage 1, if lanes i<j both qualify for a write under REQ-011 with equal wd, lane i's stored wreg SHALL be cleared; the highest-numbered lane (youngest in program order) wins.
REQ-013 On load into stage 1, whilo and llbit_we SHALL be stored as 0 when mem_valid is all-zero.
REQ-014 With no stalls and no flush, a group presented at edge n SHALL appear on the wb_ outputs after edge n+DEPTH-1, i.e. DEPTH cycles of latency.
REQ-015 retire_cnt SHALL increase by popcount(valid) of the group loaded into the final stage on each edge where the final stage loads (not on hold, bubble or flush).
REQ-016 retire_cnt SHALL wrap modulo 2^32 and SHALL NOT be cleared by flush.
REQ-017 flush together with any stall SHALL still clear all stages.

Reset
REQ-018 On rst=1 at a rising edge, all stage registers and every wb_ output SHALL become 0, and retire_cnt SHALL become 0.
REQ-019 Reset SHALL take priority over flush and stall; rst asserted mid-stall SHALL discard held groups.

Verification
REQ-020 LANES=2, DEPTH=1, no stall: lane0 wd=3, data=0xAAAA; lane1 wd=4, data=0x5555; both valid and wreg -> next cycle wb_wd={4,3}, wb_wreg=2'b11, retire_cnt=2.
REQ-021 Both lanes wd=7, wreg=1 -> wb_wreg=2'b10, lane1 data visible; lane0 wd=0, wreg=1 -> wb_wreg[0]=0.
REQ-022 stall=6'b010000 for 1 cycle -> outputs all 0 that cycle, retire_cnt unchanged; stall=6'b110000 -> outputs hold their previous values for every stalled cycle.
REQ-023 DEPTH=3, three back-to-back groups then flush=1 -> no flushed group ever reaches wb_, all wb_ outputs 0 after the flush edge, retire_cnt unchanged by the flushed groups.
REQ-024 Preload retire_cnt to 0xFFFFFFFF via retirements, then retire 2 lanes -> retire_cnt=0x00000001.
REQ-025 Assert rst during a stall[5]=1 hold -> all outputs and retire_cnt 0 after that edge; the next unstalled group passes normally.
